execute_stage: RTL and testbench

- Execute stage of the 5-stage pipeline, directly upstream of the memory stage.
- Takes decoded operands and control from the ID/EX side and computes the ALU result, the set-instruction value and branch/jump resolution.
- Registers everything the memory stage consumes (EX/MEM pipeline register) with stall-hold, flush-to-bubble and sticky halt/err handling.

---
 rtl/ex_pkg.sv | 57 +++++
 rtl/dff.sv | 17 +
 rtl/exec_alu.sv | 69 ++++++
 rtl/execute_stage.sv | 156 +++++++++++++++
 tb/tb_execute_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared encodings and the EX/MEM register layout for the execute stage.
// Default widths live here so the ALU and the stage agree on them.
package ex_pkg;

    localparam int EX_WIDTH = 16;
    localparam int EX_REGW  = 3;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_XOR   = 4'h2,
        ALU_ANDN  = 4'h3,
        ALU_ROL   = 4'h4,
        ALU_SLL   = 4'h5,
        ALU_ROR   = 4'h6,
        ALU_SRL   = 4'h7,
        ALU_SEQ   = 4'h8,
        ALU_SLT   = 4'h9,
        ALU_SLE   = 4'hA,
        ALU_SCO   = 4'hB,
        ALU_PASSB = 4'hC
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE    = 3'd0,
        BR_BEQZ    = 3'd1,
        BR_BNEZ    = 3'd2,
        BR_BLTZ    = 3'd3,
        BR_BGEZ    = 3'd4,
        BR_J       = 3'd5,
        BR_JR      = 3'd6,
        BR_ILLEGAL = 3'd7
    } br_cond_e;

    typedef struct packed {
        logic [EX_WIDTH-1:0] alu_out;
        logic [EX_WIDTH-1:0] set_val;
        logic [EX_WIDTH-1:0] reg1_data;
        logic [EX_WIDTH-1:0] reg2_data;
        logic [EX_WIDTH-1:0] instr;
        logic [EX_WIDTH-1:0] next_pc;
        logic                reg_wrt;
        logic                mem_en;
        logic                mem_wrt;
        logic                halt;
        logic                valid;
        logic [2:0]          reg_wrt_src;
        logic [EX_REGW-1:0]  write_reg;
    } exmem_t;

    localparam exmem_t EXMEM_BUBBLE = '0;

    function automatic logic alu_op_illegal(input logic [3:0] op);
        return op > ALU_PASSB;
    endfunction

endpackage

// File: rtl/dff.sv
// Plain D flop bank with synchronous active-high clear.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: non-blocking so every flop in the stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= d;
    end

endmodule

// File: rtl/exec_alu.sv
// Combinational ALU: result, set-instruction value and internal carry.
// SUB uses WISC order (B-A); compare ops report A-B on alu_out.
module exec_alu
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH
) (
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] set_val
);

    localparam int SW = $clog2(WIDTH) + 1;

    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;
    logic [3:0]       sh;
    logic [SW-1:0]    rsh;
    logic             lt;
    logic             eq;

    assign sum     = {1'b0, a} + {1'b0, b};
    assign carry   = sum[WIDTH];
    assign diff_ab = a - b;
    assign diff_ba = b - a;
    assign sh      = b[3:0];
    assign rsh     = SW'(WIDTH) - SW'(sh);
    assign lt      = $signed(a) < $signed(b);
    assign eq      = (a == b);

    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        alu_out = '0;
        set_val = '0;
        case (alu_op)
            ALU_ADD:   alu_out = sum[WIDTH-1:0];
            ALU_SUB:   alu_out = diff_ba;
            ALU_XOR:   alu_out = a ^ b;
            ALU_ANDN:  alu_out = a & ~b;
            ALU_ROL:   alu_out = (a << sh) | (a >> rsh);
            ALU_SLL:   alu_out = a << sh;
            ALU_ROR:   alu_out = (a >> sh) | (a << rsh);
            ALU_SRL:   alu_out = a >> sh;
            ALU_SEQ: begin
                alu_out = diff_ab;
                set_val = WIDTH'(eq);
            end
            ALU_SLT: begin
                alu_out = diff_ab;
                set_val = WIDTH'(lt);
            end
            ALU_SLE: begin
                alu_out = diff_ab;
                set_val = WIDTH'(lt | eq);
            end
            ALU_SCO: begin
                alu_out = sum[WIDTH-1:0];
                set_val = WIDTH'(carry);
            end
            ALU_PASSB: alu_out = b;
            default: ;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand mux, ALU, branch resolution and the EX/MEM register
// with stall-hold, flush-to-bubble, sticky halt and sticky illegal-op error.
module execute_stage
    import ex_pkg::*;
#(
    parameter int WIDTH = EX_WIDTH,
    parameter int REGW  = EX_REGW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validIn,
    input  logic             stall,
    input  logic             flush,
    input  logic [WIDTH-1:0] reg1Data,
    input  logic [WIDTH-1:0] reg2Data,
    input  logic [WIDTH-1:0] imm,
    input  logic             aluSrc,
    input  logic [3:0]       aluOp,
    input  logic [2:0]       brCond,
    input  logic [WIDTH-1:0] instr,
    input  logic [WIDTH-1:0] nextPc,
    input  logic             regWrt,
    input  logic             memEn,
    input  logic             memWrt,
    input  logic             halt,
    input  logic [2:0]       regWrtSrc,
    input  logic [REGW-1:0]  writeReg,
    output logic [WIDTH-1:0] aluOut,
    output logic [WIDTH-1:0] setVal,
    output logic [WIDTH-1:0] reg1DataOut,
    output logic [WIDTH-1:0] reg2DataOut,
    output logic [WIDTH-1:0] instrOut,
    output logic [WIDTH-1:0] nextPcOut,
    output logic             regWrtOut,
    output logic             memEnOut,
    output logic             memWrtOut,
    output logic             haltOut,
    output logic             validOut,
    output logic [2:0]       regWrtSrcOut,
    output logic [REGW-1:0]  writeRegOut,
    output logic             err,
    output logic             branchTaken,
    output logic [WIDTH-1:0] branchTarget
);

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] set_res;
    logic             cond_true;
    logic             illegal;
    logic             live;

    exmem_t exmem_d, exmem_q;
    logic   halt_seen_d, halt_seen_q;
    logic   err_d, err_q;

    assign op_b = aluSrc ? imm : reg2Data;

    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .alu_op  (aluOp),
        .a       (reg1Data),
        .b       (op_b),
        .alu_out (alu_res),
        .set_val (set_res)
    );

    always_comb begin
        cond_true    = 1'b0;
        branchTarget = nextPc + imm;
        case (brCond)
            BR_BEQZ: cond_true = (reg1Data == '0);
            BR_BNEZ: cond_true = (reg1Data != '0);
            BR_BLTZ: cond_true = reg1Data[WIDTH-1];
            BR_BGEZ: cond_true = ~reg1Data[WIDTH-1];
            BR_J:    cond_true = 1'b1;
            BR_JR: begin
                cond_true    = 1'b1;
                branchTarget = reg1Data + imm;
            end
            default: ;
        endcase
    end

    assign branchTaken = validIn & ~stall & ~halt_seen_q & cond_true;

    // Once halted, nothing younger may reach the memory stage.
    assign live    = validIn & ~halt_seen_q;
    assign illegal = alu_op_illegal(aluOp) | (brCond == BR_ILLEGAL);

    // Priority below rst (handled in the flops): flush > stall > load.
    always_comb begin
        exmem_d     = exmem_q;
        halt_seen_d = halt_seen_q;
        err_d       = err_q;
        if (flush) begin
            exmem_d = EXMEM_BUBBLE;
        end else if (!stall) begin
            exmem_d      = EXMEM_BUBBLE;
            exmem_d.halt = halt_seen_q;
            if (live) begin
                exmem_d.alu_out     = alu_res;
                exmem_d.set_val     = set_res;
                exmem_d.reg1_data   = reg1Data;
                exmem_d.reg2_data   = reg2Data;
                exmem_d.instr       = instr;
                exmem_d.next_pc     = nextPc;
                exmem_d.reg_wrt     = regWrt & ~illegal;
                exmem_d.mem_en      = memEn;
                exmem_d.mem_wrt     = memWrt & ~illegal;
                exmem_d.halt        = halt;
                exmem_d.valid       = 1'b1;
                exmem_d.reg_wrt_src = regWrtSrc;
                exmem_d.write_reg   = writeReg;
                halt_seen_d         = halt;
                err_d               = err_q | illegal;
            end
        end
    end

    dff #(.W($bits(exmem_t))) u_exmem_reg (
        .clk (clk),
        .rst (rst),
        .d   (exmem_d),
        .q   (exmem_q)
    );

    dff #(.W(1)) u_halt_seen_reg (
        .clk (clk),
        .rst (rst),
        .d   (halt_seen_d),
        .q   (halt_seen_q)
    );

    dff #(.W(1)) u_err_reg (
        .clk (clk),
        .rst (rst),
        .d   (err_d),
        .q   (err_q)
    );

    assign aluOut       = exmem_q.alu_out;
    assign setVal       = exmem_q.set_val;
    assign reg1DataOut  = exmem_q.reg1_data;
    assign reg2DataOut  = exmem_q.reg2_data;
    assign instrOut     = exmem_q.instr;
    assign nextPcOut    = exmem_q.next_pc;
    assign regWrtOut    = exmem_q.reg_wrt;
    assign memEnOut     = exmem_q.mem_en;
    assign memWrtOut    = exmem_q.mem_wrt;
    assign haltOut      = exmem_q.halt;
    assign validOut     = exmem_q.valid;
    assign regWrtSrcOut = exmem_q.reg_wrt_src;
    assign writeRegOut  = exmem_q.write_reg;
    assign err          = err_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, hand-written
// stall/flush/halt/illegal sequences, then random stimulus against a model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst, validIn, stall, flush, aluSrc;
    logic [15:0] reg1Data, reg2Data, imm, instr, nextPc;
    logic [3:0]  aluOp;
    logic [2:0]  brCond, regWrtSrc, writeReg;
    logic        regWrt, memEn, memWrt, halt;
    logic [15:0] aluOut, setVal, reg1DataOut, reg2DataOut, instrOut, nextPcOut;
    logic        regWrtOut, memEnOut, memWrtOut, haltOut, validOut, err;
    logic [2:0]  regWrtSrcOut, writeRegOut;
    logic        branchTaken;
    logic [15:0] branchTarget;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk(clk), .rst(rst), .validIn(validIn), .stall(stall), .flush(flush),
        .reg1Data(reg1Data), .reg2Data(reg2Data), .imm(imm), .aluSrc(aluSrc),
        .aluOp(aluOp), .brCond(brCond), .instr(instr), .nextPc(nextPc),
        .regWrt(regWrt), .memEn(memEn), .memWrt(memWrt), .halt(halt),
        .regWrtSrc(regWrtSrc), .writeReg(writeReg),
        .aluOut(aluOut), .setVal(setVal), .reg1DataOut(reg1DataOut),
        .reg2DataOut(reg2DataOut), .instrOut(instrOut), .nextPcOut(nextPcOut),
        .regWrtOut(regWrtOut), .memEnOut(memEnOut), .memWrtOut(memWrtOut),
        .haltOut(haltOut), .validOut(validOut), .regWrtSrcOut(regWrtSrcOut),
        .writeRegOut(writeRegOut), .err(err), .branchTaken(branchTaken),
        .branchTarget(branchTarget)
    );

    typedef struct {
        logic        rst, valid, stall, flush, src;
        logic [15:0] r1, r2, imm, instr, npc;
        logic [3:0]  op;
        logic [2:0]  br, rws, wr;
        logic        reg_wrt, mem_en, mem_wrt, halt;
    } stim_t;

    typedef struct {
        logic [15:0] alu_out, set_val, r1, r2, instr, npc;
        logic        reg_wrt, mem_en, mem_wrt, halt, valid, err;
        logic [2:0]  rws, wr;
    } exp_t;

    typedef struct {
        string       name;
        stim_t       s;
        logic [15:0] alu;
        logic [15:0] setv;
        logic        taken;
        logic [15:0] target;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    exp_t  mdl;
    logic  mdl_seen;
    vec_t  vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic stim_t mk(input logic [3:0] op, input logic [15:0] r1, input logic [15:0] r2,
                                 input logic [15:0] immv, input logic src, input logic [2:0] br,
                                 input logic [15:0] npc);
        stim_t s;
        s       = idle();
        s.valid = 1'b1;
        s.op    = op;
        s.r1    = r1;
        s.r2    = r2;
        s.imm   = immv;
        s.src   = src;
        s.br    = br;
        s.npc   = npc;
        s.instr = r1 ^ {op, 12'h5A5};
        s.reg_wrt = 1'b1;
        s.rws   = 3'd2;
        s.wr    = 3'd5;
        return s;
    endfunction

    function automatic longint sgn(input longint v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    // Reference ALU in plain integer arithmetic on 16-bit values.
    task automatic ref_alu(input logic [3:0] op, input logic [15:0] a16, input logic [15:0] b16,
                           output logic [15:0] res, output logic [15:0] setv);
        longint a, b, p, q, r;
        a = longint'(a16);
        b = longint'(b16);
        p = longint'(1) << b16[3:0];
        q = 65536 / p;
        r = 0;
        setv = 16'h0;
        case (op)
            4'd0:  r = (a + b) % 65536;
            4'd1:  r = (b - a + 65536) % 65536;
            4'd2:  r = longint'(a16 ^ b16);
            4'd3:  r = longint'(a16 & ~b16);
            4'd4:  r = (a * p) % 65536 + a / q;
            4'd5:  r = (a * p) % 65536;
            4'd6:  r = a / p + (a % p) * q;
            4'd7:  r = a / p;
            4'd8:  begin r = (a - b + 65536) % 65536; setv = (a == b) ? 16'd1 : 16'd0; end
            4'd9:  begin r = (a - b + 65536) % 65536; setv = (sgn(a) < sgn(b)) ? 16'd1 : 16'd0; end
            4'd10: begin r = (a - b + 65536) % 65536; setv = (sgn(a) <= sgn(b)) ? 16'd1 : 16'd0; end
            4'd11: begin r = (a + b) % 65536; setv = (a + b >= 65536) ? 16'd1 : 16'd0; end
            4'd12: r = b;
            default: r = 0;
        endcase
        res = r[15:0];
    endtask

    task automatic ref_branch(input stim_t s, input logic seen, output logic tk, output logic [15:0] tg);
        longint base;
        logic   cond;
        base = (s.br == 3'd6) ? longint'(s.r1) : longint'(s.npc);
        tg   = 16'((base + longint'(s.imm)) % 65536);
        case (s.br)
            3'd1: cond = (s.r1 == 16'h0);
            3'd2: cond = (s.r1 != 16'h0);
            3'd3: cond = (s.r1 >= 16'h8000);
            3'd4: cond = (s.r1 <  16'h8000);
            3'd5, 3'd6: cond = 1'b1;
            default: cond = 1'b0;
        endcase
        tk = s.valid && !s.stall && !seen && cond;
    endtask

    // Next EX/MEM contents: rst > flush > stall > load.
    task automatic mdl_step(input stim_t s);
        logic kept_err;
        logic ill;
        kept_err = mdl.err;
        ill = (s.op >= 4'd13) || (s.br == 3'd7);
        if (s.rst) begin
            mdl = '{default: '0};
            mdl_seen = 1'b0;
        end else if (s.flush) begin
            mdl = '{default: '0};
            mdl.err = kept_err;
        end else if (!s.stall) begin
            mdl = '{default: '0};
            mdl.err  = kept_err;
            mdl.halt = mdl_seen;
            if (s.valid && !mdl_seen) begin
                ref_alu(s.op, s.r1, s.src ? s.imm : s.r2, mdl.alu_out, mdl.set_val);
                mdl.r1      = s.r1;
                mdl.r2      = s.r2;
                mdl.instr   = s.instr;
                mdl.npc     = s.npc;
                mdl.reg_wrt = s.reg_wrt && !ill;
                mdl.mem_en  = s.mem_en;
                mdl.mem_wrt = s.mem_wrt && !ill;
                mdl.halt    = s.halt;
                mdl.valid   = 1'b1;
                mdl.rws     = s.rws;
                mdl.wr      = s.wr;
                mdl.err     = kept_err || ill;
                if (s.halt) mdl_seen = 1'b1;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        rst = s.rst; validIn = s.valid; stall = s.stall; flush = s.flush;
        reg1Data = s.r1; reg2Data = s.r2; imm = s.imm; aluSrc = s.src;
        aluOp = s.op; brCond = s.br; instr = s.instr; nextPc = s.npc;
        regWrt = s.reg_wrt; memEn = s.mem_en; memWrt = s.mem_wrt; halt = s.halt;
        regWrtSrc = s.rws; writeReg = s.wr;
    endtask

    // Drive just after a falling edge, check branch outputs, then check the
    // registered outputs at the next falling edge.
    task automatic apply(input stim_t s, output logic tk, output logic [15:0] tg);
        logic        etk;
        logic [15:0] etg;
        drive(s);
        #1;
        tk = branchTaken;
        tg = branchTarget;
        ref_branch(s, mdl_seen, etk, etg);
        check("branchTaken", 64'(tk), 64'(etk));
        check("branchTarget", 64'(tg), 64'(etg));
        mdl_step(s);
        @(negedge clk);
        check("aluOut", 64'(aluOut), 64'(mdl.alu_out));
        check("setVal", 64'(setVal), 64'(mdl.set_val));
        check("passthru", {reg1DataOut, reg2DataOut, instrOut, nextPcOut},
              {mdl.r1, mdl.r2, mdl.instr, mdl.npc});
        check("ctrl", 64'({regWrtOut, memEnOut, memWrtOut, haltOut, validOut, regWrtSrcOut, writeRegOut}),
              64'({mdl.reg_wrt, mdl.mem_en, mdl.mem_wrt, mdl.halt, mdl.valid, mdl.rws, mdl.wr}));
        check("err", 64'(err), 64'(mdl.err));
    endtask

    task automatic step(input stim_t s);
        logic        tk;
        logic [15:0] tg;
        apply(s, tk, tg);
    endtask

    task automatic do_reset(input logic stall_too);
        stim_t s;
        s = mk(4'd2, 16'h1234, 16'h4321, 16'h0, 1'b0, 3'd0, 16'h0);
        s.valid = 1'b0;
        s.rst   = 1'b1;
        s.stall = stall_too;
        s.flush = stall_too;
        step(s);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_data"}, {aluOut, setVal, reg1DataOut, reg2DataOut}, 64'h0);
        check({name, "_ctrl"}, 64'({instrOut, nextPcOut, regWrtOut, memEnOut, memWrtOut, haltOut,
                                     validOut, regWrtSrcOut, writeRegOut, err}), 64'h0);
    endtask

    initial begin
        stim_t       s;
        logic        tk;
        logic [15:0] tg;

        mdl = '{default: '0};
        mdl_seen = 1'b0;

        vecs.push_back('{"add",      mk(4'h0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h8000, 16'h0, 1'b0, 16'h0000});
        vecs.push_back('{"sco",      mk(4'hB, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h8000, 16'h0, 1'b0, 16'h0000});
        vecs.push_back('{"sco_cy",   mk(4'hB, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h0000, 16'h1, 1'b0, 16'h0000});
        vecs.push_back('{"sub",      mk(4'h1, 16'h0003, 16'h0000, 16'h0005, 1'b1, 3'd0, 16'h0000), 16'h0002, 16'h0, 1'b0, 16'h0005});
        vecs.push_back('{"slt",      mk(4'h9, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'hFFFE, 16'h1, 1'b0, 16'h0000});
        vecs.push_back('{"beqz",     mk(4'h0, 16'h0000, 16'h0000, 16'hFFFA, 1'b0, 3'd1, 16'h0010), 16'h0000, 16'h0, 1'b1, 16'h000A});
        vecs.push_back('{"xor",      mk(4'h2, 16'h00FF, 16'h0F0F, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h0FF0, 16'h0, 1'b0, 16'h0000});
        vecs.push_back('{"andn",     mk(4'h3, 16'hF0F0, 16'hFF00, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h00F0, 16'h0, 1'b0, 16'h0000});
        vecs.push_back('{"rol",      mk(4'h4, 16'h8001, 16'h0001, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h0003, 16'h0, 1'b0, 16'h0000});
        vecs.push_back('{"sll",      mk(4'h5, 16'h0001, 16'h0004, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h0010, 16'h0, 1'b0, 16'h0000});
        vecs.push_back('{"ror",      mk(4'h6, 16'h8001, 16'h0001, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'hC000, 16'h0, 1'b0, 16'h0000});
        vecs.push_back('{"srl",      mk(4'h7, 16'h8000, 16'h000F, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h0001, 16'h0, 1'b0, 16'h0000});
        vecs.push_back('{"seq",      mk(4'h8, 16'h1234, 16'h1234, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h0000, 16'h1, 1'b0, 16'h0000});
        vecs.push_back('{"sle_eq",   mk(4'hA, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h0000, 16'h1, 1'b0, 16'h0000});
        vecs.push_back('{"sle_neg",  mk(4'hA, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 3'd0, 16'h0000), 16'h0002, 16'h0, 1'b0, 16'h0000});
        vecs.push_back('{"passb",    mk(4'hC, 16'h1111, 16'h0000, 16'hABCD, 1'b1, 3'd0, 16'h0000), 16'hABCD, 16'h0, 1'b0, 16'hABCD});
        vecs.push_back('{"jr",       mk(4'h0, 16'h0100, 16'h0000, 16'h0004, 1'b0, 3'd6, 16'h0000), 16'h0100, 16'h0, 1'b1, 16'h0104});
        vecs.push_back('{"bltz",     mk(4'h0, 16'h8000, 16'h0000, 16'h0002, 1'b0, 3'd3, 16'h0020), 16'h8000, 16'h0, 1'b1, 16'h0022});
        vecs.push_back('{"bnez_nt",  mk(4'h0, 16'h0000, 16'h0005, 16'h0006, 1'b0, 3'd2, 16'h0040), 16'h0005, 16'h0, 1'b0, 16'h0046});
        vecs.push_back('{"j",        mk(4'h0, 16'h0001, 16'h0001, 16'h0010, 1'b0, 3'd5, 16'h0100), 16'h0002, 16'h0, 1'b1, 16'h0110});

        // Reset state
        do_reset(1'b0);
        check_all_zero("reset");

        // Directed vector table
        foreach (vecs[i]) begin
            apply(vecs[i].s, tk, tg);
            check({vecs[i].name, "_taken"}, 64'(tk), 64'(vecs[i].taken));
            check({vecs[i].name, "_target"}, 64'(tg), 64'(vecs[i].target));
            check({vecs[i].name, "_alu"}, 64'(aluOut), 64'(vecs[i].alu));
            check({vecs[i].name, "_set"}, 64'(setVal), 64'(vecs[i].setv));
            check({vecs[i].name, "_valid"}, 64'(validOut), 64'h1);
        end

        // Branch request suppressed by stall
        s = vecs[5].s;
        s.stall = 1'b1;
        apply(s, tk, tg);
        check("beqz_stall_taken", 64'(tk), 64'h0);

        // Stall holds for three cycles, then flush beats stall
        s = mk(4'h0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 3'd0, 16'h0000);
        s.mem_en = 1'b1;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = mk(4'h2, 16'(i * 7 + 3), 16'h5555, 16'h0, 1'b0, 3'd1, 16'h0);
            s.stall = 1'b1;
            step(s);
            check("stall_hold_alu", 64'(aluOut), 64'h8000);
            check("stall_hold_ctrl", 64'({validOut, regWrtOut, memEnOut}), 64'b111);
        end
        s.flush = 1'b1;
        step(s);
        check("flush_stall_ctrl", 64'({validOut, regWrtOut, memEnOut}), 64'b000);

        // Halt: later loads become bubbles, haltOut stays up until rst
        s = mk(4'h0, 16'h0001, 16'h0001, 16'h0, 1'b0, 3'd0, 16'h0);
        s.halt = 1'b1;
        step(s);
        check("halt_set", 64'(haltOut), 64'h1);
        s = mk(4'h0, 16'h0002, 16'h0003, 16'h0, 1'b0, 3'd0, 16'h0);
        step(s);
        check("halt_bubble", 64'({regWrtOut, haltOut, validOut}), 64'b010);
        apply(vecs[5].s, tk, tg);
        check("halt_no_branch", 64'(tk), 64'h0);
        check("halt_still", 64'(haltOut), 64'h1);
        do_reset(1'b0);
        check_all_zero("halt_rst");

        // Illegal ops: sticky err, writes suppressed, invalid ops ignored
        s = mk(4'hE, 16'h0001, 16'h0002, 16'h0, 1'b0, 3'd0, 16'h0);
        s.mem_wrt = 1'b1;
        step(s);
        check("illegal_err", 64'(err), 64'h1);
        check("illegal_wr", 64'({regWrtOut, memWrtOut, validOut}), 64'b001);
        s = idle();
        s.flush = 1'b1;
        step(s);
        check("illegal_err_flush", 64'(err), 64'h1);
        do_reset(1'b1);
        check_all_zero("rst_mid_stall_flush");
        s = mk(4'hE, 16'h0001, 16'h0002, 16'h0, 1'b0, 3'd0, 16'h0);
        s.valid = 1'b0;
        step(s);
        check("illegal_invalid_err", 64'(err), 64'h0);
        s = mk(4'h0, 16'h0001, 16'h0002, 16'h0, 1'b0, 3'd7, 16'h0);
        step(s);
        check("brcond7_err", 64'(err), 64'h1);
        do_reset(1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.rst     = ($urandom_range(0, 63) == 0);
            s.flush   = ($urandom_range(0, 9) == 0);
            s.stall   = ($urandom_range(0, 5) == 0);
            s.valid   = ($urandom_range(0, 3) != 0);
            s.r1      = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            s.r2      = 16'($urandom);
            s.imm     = 16'($urandom);
            s.src     = 1'($urandom);
            s.op      = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 12));
            s.br      = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            s.instr   = 16'($urandom);
            s.npc     = 16'($urandom);
            s.reg_wrt = 1'($urandom);
            s.mem_en  = 1'($urandom);
            s.mem_wrt = 1'($urandom);
            s.halt    = ($urandom_range(0, 19) == 0);
            s.rws     = 3'($urandom);
            s.wr      = 3'($urandom);
            step(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
